// File: rtl/alu_sched_if.sv
// Request/response handshake bundle between requesters and alu_sched.
interface alu_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_data;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_data
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered 4-bit ALU among requesters.
// Optional op counter enabled by ALU_SCHED_STATS_EN.
module alu_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_sched_if.slave bus,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0] ops_done,
  input  logic        stats_clr
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int IW   = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]    last;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               grant;
  logic               rsp_hs;
  logic [NUM_REQ-1:0] ready_oh;
  logic [3:0]         sel_a;
  logic [3:0]         sel_b;
  logic [1:0]         sel_op;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [3:0]         rsp_data_q;

  // Search upward from last+1, wrapping at NUM_REQ.
  always_comb begin : arb
    logic [IW-1:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (!gnt_any && bus.req_valid[idx[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a  = bus.req_a[4*i +: 4];
        sel_b  = bus.req_b[4*i +: 4];
        sel_op = bus.req_op[2*i +: 2];
      end
    end
  end

  assign grant  = (state == IDLE) && gnt_any;
  assign rsp_hs = (state == RESP) && bus.rsp_ready;

  always_comb begin
    ready_oh = '0;
    if (grant && !rst) begin
      ready_oh[gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = ready_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands persist between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      gid    <= '0;
      last   <= ID_W'(NUM_REQ - 1);
    end else if (grant) begin
      alu_a  <= sel_a;
      alu_b  <= sel_b;
      alu_op <= sel_op;
      gid    <= gnt_idx;
      last   <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else if (state == CAPT) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gid;
      rsp_data_q  <= alu_result;
    end else if (rsp_hs) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (stats_clr) begin
      ops_done <= '0;
    end else if (rsp_hs && ops_done != 16'hFFFF) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule
